// File: rtl/l1_cache_controller.sv
// l1_cache_controller: direct-mapped, write-through, no-write-allocate L1 cache.
// 128 lines x 8 words x 32 bits, 14-bit tag, one valid bit per line.
// CPU side: single outstanding request, strobe/ack handshake.
// SDRAM side: 8-word burst reads for line fills, single-word writes.
// Optional build macro L1_CACHE_STATS_EN adds read hit/miss counters
// (hit_count, miss_count). Without it, the ports and counters do not exist.

module l1_cache_controller (
    input  logic         clk,
    input  logic         reset,
    input  logic [23:0]  cpu_addr,
    input  logic [31:0]  cpu_data,
    input  logic         cpu_we,
    input  logic         cpu_start,
    output logic [31:0]  cpu_q,
    output logic         cpu_ack,
    output logic         cpu_busy,
    output logic [23:0]  sdc_addr,
    output logic [31:0]  sdc_data,
    output logic         sdc_we,
    output logic         sdc_start,
    input  logic [255:0] sdc_q,
    input  logic         sdc_ack,
    input  logic         sdc_busy
`ifdef L1_CACHE_STATS_EN
    ,
    output logic [31:0]  hit_count,
    output logic [31:0]  miss_count
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        MISS_REQ,
        MISS_WAIT,
        WR_REQ,
        WR_WAIT,
        DONE
    } state_t;

    state_t state, state_next;

    // Latched request; the CPU holds its inputs too, but the cache works
    // only from its own copy once the request is accepted.
    logic [23:0] req_addr;
    logic [31:0] req_data;
    logic        req_we;
    logic        req_hit;

    logic [2:0]  req_off;
    logic [6:0]  req_idx;
    logic [13:0] req_tag;

    assign req_off = req_addr[2:0];
    assign req_idx = req_addr[9:3];
    assign req_tag = req_addr[23:10];

    // Cache storage
    logic [255:0] data_mem [128];
    logic [13:0]  tag_mem  [128];
    logic [127:0] valid;

    logic         lookup_hit;
    logic [255:0] line_rd;

    assign lookup_hit = valid[req_idx] && (tag_mem[req_idx] == req_tag);
    assign line_rd    = data_mem[req_idx];
    assign cpu_busy   = (state != IDLE);

    // Single-cycle control strobes decoded from the current state
    logic accept;
    logic rd_hit;
    logic rd_miss;
    logic wr_lookup;
    logic issue_rd;
    logic issue_wr;
    logic fill;
    logic wr_done;

    // Next-state and strobe decode
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves
        // a signal unassigned and no latch is inferred.
        state_next = state;
        accept     = 1'b0;
        rd_hit     = 1'b0;
        rd_miss    = 1'b0;
        wr_lookup  = 1'b0;
        issue_rd   = 1'b0;
        issue_wr   = 1'b0;
        fill       = 1'b0;
        wr_done    = 1'b0;
        case (state)
            IDLE: begin
                if (cpu_start) begin
                    accept     = 1'b1;
                    state_next = LOOKUP;
                end
            end
            LOOKUP: begin
                if (req_we) begin
                    wr_lookup  = 1'b1;
                    state_next = WR_REQ;
                end else if (lookup_hit) begin
                    rd_hit     = 1'b1;
                    state_next = DONE;
                end else begin
                    rd_miss    = 1'b1;
                    state_next = MISS_REQ;
                end
            end
            MISS_REQ: begin
                if (!sdc_busy) begin
                    issue_rd   = 1'b1;
                    state_next = MISS_WAIT;
                end
            end
            MISS_WAIT: begin
                if (sdc_ack) begin
                    fill       = 1'b1;
                    state_next = DONE;
                end
            end
            WR_REQ: begin
                if (!sdc_busy) begin
                    issue_wr   = 1'b1;
                    state_next = WR_WAIT;
                end
            end
            WR_WAIT: begin
                if (sdc_ack) begin
                    wr_done    = 1'b1;
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of block evaluation order.
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Request capture; the hit flag of a write is remembered for the
    // deferred word update once the write-through completes
    always_ff @(posedge clk) begin
        if (accept) begin
            req_addr <= cpu_addr;
            req_data <= cpu_data;
            req_we   <= cpu_we;
        end
        if (wr_lookup) begin
            req_hit <= lookup_hit;
        end
    end

    // CPU and SDRAM output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            cpu_ack   <= 1'b0;
            cpu_q     <= '0;
            sdc_start <= 1'b0;
            sdc_we    <= 1'b0;
            sdc_addr  <= '0;
            sdc_data  <= '0;
        end else begin
            cpu_ack <= rd_hit | fill | wr_done;
            if (rd_hit) begin
                cpu_q <= line_rd[{req_off, 5'b00000} +: 32];
            end else if (fill) begin
                cpu_q <= sdc_q[{req_off, 5'b00000} +: 32];
            end
            if (issue_rd) begin
                sdc_start <= 1'b1;
                sdc_we    <= 1'b0;
                sdc_addr  <= {req_addr[23:3], 3'b000};
            end else if (issue_wr) begin
                sdc_start <= 1'b1;
                sdc_we    <= 1'b1;
                sdc_addr  <= req_addr;
                sdc_data  <= req_data;
            end else if (fill || wr_done) begin
                sdc_start <= 1'b0;
            end
        end
    end

    // Valid bits: the only cache state that must be cleared
    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= '0;
        end else if (fill) begin
            valid[req_idx] <= 1'b1;
        end
    end

    // Tag and data arrays; a write hit updates its word only after the
    // SDRAM has accepted it, so an abandoned write leaves the line untouched
    always_ff @(posedge clk) begin
        // NOTE: the arrays are deliberately not reset; the cleared valid bits
        // make their contents unobservable and keep them mappable to RAM.
        if (!reset) begin
            if (fill) begin
                data_mem[req_idx] <= sdc_q;
                tag_mem[req_idx]  <= req_tag;
            end else if (wr_done && req_hit) begin
                data_mem[req_idx][{req_off, 5'b00000} +: 32] <= req_data;
            end
        end
    end

`ifdef L1_CACHE_STATS_EN
    // Read hit / read miss counters, wrapping naturally at 2^32
    always_ff @(posedge clk) begin
        if (reset) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (rd_hit) begin
                hit_count <= hit_count + 32'd1;
            end
            if (rd_miss) begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_l1_cache_controller.sv
// tb_l1_cache_controller: table-driven directed vectors, hand-written
// multi-cycle sequences and a randomized phase checked against a
// behavioural cache/SDRAM model.

module tb_l1_cache_controller;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [23:0]  cpu_addr = '0;
    logic [31:0]  cpu_data = '0;
    logic         cpu_we = 1'b0;
    logic         cpu_start = 1'b0;
    logic [31:0]  cpu_q;
    logic         cpu_ack;
    logic         cpu_busy;
    logic [23:0]  sdc_addr;
    logic [31:0]  sdc_data;
    logic         sdc_we;
    logic         sdc_start;
    logic [255:0] sdc_q_r = '0;
    logic         model_ack = 1'b0;
    logic         stray_ack = 1'b0;
    logic         sdc_busy = 1'b0;
`ifdef L1_CACHE_STATS_EN
    logic [31:0]  hit_count;
    logic [31:0]  miss_count;
`endif

    l1_cache_controller dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_addr  (cpu_addr),
        .cpu_data  (cpu_data),
        .cpu_we    (cpu_we),
        .cpu_start (cpu_start),
        .cpu_q     (cpu_q),
        .cpu_ack   (cpu_ack),
        .cpu_busy  (cpu_busy),
        .sdc_addr  (sdc_addr),
        .sdc_data  (sdc_data),
        .sdc_we    (sdc_we),
        .sdc_start (sdc_start),
        .sdc_q     (sdc_q_r),
        .sdc_ack   (model_ack | stray_ack),
        .sdc_busy  (sdc_busy)
`ifdef L1_CACHE_STATS_EN
        ,
        .hit_count (hit_count),
        .miss_count(miss_count)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- SDRAM model ----------------
    logic [31:0] sdram_mem [logic [23:0]];
    int          sdram_lat = 2;
    int          xfer_cyc = 0;
    logic        prev_start = 1'b0;
    logic [23:0] held_addr = '0;
    logic        held_we = 1'b0;
    int          rd_starts = 0;
    int          wr_starts = 0;
    int          ack_events = 0;
    int          proto_err = 0;
    logic [23:0] last_rd_addr = '0;
    logic [23:0] last_wr_addr = '0;
    logic [31:0] last_wr_data = '0;

    function automatic logic [31:0] mem_rd(input logic [23:0] a);
        if (sdram_mem.exists(a)) return sdram_mem[a];
        if (a >= 24'h000010 && a <= 24'h000017) return 32'hA0 + 32'(a - 24'h000010);
        return {8'h5A, a};
    endfunction

    always @(negedge clk) begin
        model_ack = 1'b0;
        if (cpu_ack) ack_events++;
        if (reset) begin
            prev_start = 1'b0;
            xfer_cyc   = 0;
        end else begin
            if (sdc_start && !prev_start) begin
                xfer_cyc  = 0;
                held_addr = sdc_addr;
                held_we   = sdc_we;
                if (sdc_we) begin
                    wr_starts++;
                    last_wr_addr = sdc_addr;
                    last_wr_data = sdc_data;
                end else begin
                    rd_starts++;
                    last_rd_addr = sdc_addr;
                end
            end else if (sdc_start && (sdc_addr !== held_addr || sdc_we !== held_we)) begin
                proto_err++;
            end
            if (sdc_start) begin
                xfer_cyc++;
                if (xfer_cyc == sdram_lat) begin
                    if (sdc_we) begin
                        sdram_mem[sdc_addr] = sdc_data;
                    end else begin
                        for (int n = 0; n < 8; n++)
                            sdc_q_r[32*n +: 32] = mem_rd({sdc_addr[23:3], 3'(n)});
                    end
                    model_ack = 1'b1;
                end
            end
            prev_start = sdc_start;
        end
    end

    // ---------------- CPU request driver ----------------
    task automatic do_req(input string nm, input logic [23:0] a, input logic w,
                          input logic [31:0] d, output logic [31:0] q,
                          output int lat, output int acks);
        int a0;
        bit done;
        a0   = ack_events;
        q    = '0;
        lat  = 0;
        done = 1'b0;
        @(negedge clk);
        cpu_addr  = a;
        cpu_we    = w;
        cpu_data  = d;
        cpu_start = 1'b1;
        for (int k = 1; k <= 300 && !done; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 1) cpu_start = 1'b0;
            if (cpu_ack) begin
                done = 1'b1;
                lat  = k;
                q    = cpu_q;
            end
        end
        if (!done) check({nm, " ack timeout"}, 64'd0, 64'd1);
        @(posedge clk);
        @(negedge clk);
        check({nm, " idle after done"}, {cpu_busy, cpu_ack}, 64'd0);
        acks = ack_events - a0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [23:0] addr;
        logic        we;
        logic [31:0] data;
        logic [31:0] exp_q;
        int          exp_fill;
        int          exp_wr;
        int          exp_lat;
    } vec_t;

    vec_t vecs[10];

    // ---------------- reference cache model ----------------
    logic [13:0] m_tag   [128];
    bit          m_valid [128];

    initial begin
        logic [31:0] q;
        int lat, acks, r0, w0, a0, hi, extra;
        bit got;
        logic [6:0]  idx_pool [4];
        logic [13:0] tag_pool [3];

        vecs[0] = '{24'h000010, 1'b0, 32'h0,        32'h000000A0, 1, 0, 0};
        vecs[1] = '{24'h000013, 1'b0, 32'h0,        32'h000000A3, 0, 0, 2};
        vecs[2] = '{24'h000013, 1'b1, 32'hDEADBEEF, 32'h0,        0, 1, 0};
        vecs[3] = '{24'h000013, 1'b0, 32'h0,        32'hDEADBEEF, 0, 0, 2};
        vecs[4] = '{24'h000410, 1'b0, 32'h0,        32'h5A000410, 1, 0, 0};
        vecs[5] = '{24'h000010, 1'b0, 32'h0,        32'h000000A0, 1, 0, 0};
        vecs[6] = '{24'h000013, 1'b0, 32'h0,        32'hDEADBEEF, 0, 0, 2};
        vecs[7] = '{24'h002011, 1'b1, 32'h12345678, 32'h0,        0, 1, 0};
        vecs[8] = '{24'h002011, 1'b0, 32'h0,        32'h12345678, 1, 0, 0};
        vecs[9] = '{24'h000013, 1'b0, 32'h0,        32'hDEADBEEF, 1, 0, 0};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset outputs",
              {cpu_ack, cpu_busy, sdc_start, sdc_we}, 64'd0);
        check("reset cpu_q", cpu_q, 64'd0);
        check("reset sdc_addr/data", {sdc_addr, sdc_data}, 64'd0);
        reset = 1'b0;

        // Directed table: fill, hit, write-through, conflict, no-write-allocate
        foreach (vecs[i]) begin
            r0 = rd_starts;
            w0 = wr_starts;
            do_req($sformatf("vec%0d", i), vecs[i].addr, vecs[i].we, vecs[i].data, q, lat, acks);
            check($sformatf("vec%0d ack count", i), acks, 64'd1);
            check($sformatf("vec%0d fills", i), rd_starts - r0, vecs[i].exp_fill);
            check($sformatf("vec%0d writes", i), wr_starts - w0, vecs[i].exp_wr);
            if (!vecs[i].we) check($sformatf("vec%0d cpu_q", i), q, vecs[i].exp_q);
            if (vecs[i].exp_lat != 0) check($sformatf("vec%0d hit latency", i), lat, vecs[i].exp_lat);
            if (vecs[i].exp_fill != 0)
                check($sformatf("vec%0d fill addr", i), last_rd_addr, {vecs[i].addr[23:3], 3'b000});
            if (vecs[i].we)
                check($sformatf("vec%0d write addr/data", i), {last_wr_addr, last_wr_data},
                      {vecs[i].addr, vecs[i].data});
        end
`ifdef L1_CACHE_STATS_EN
        check("hit_count", hit_count, 64'd3);
        check("miss_count", miss_count, 64'd5);
`endif

        // SDRAM busy for several cycles during a miss, with a stray sdc_ack
        r0 = rd_starts;
        a0 = ack_events;
        hi = 0;
        @(negedge clk);
        sdc_busy  = 1'b1;
        cpu_addr  = 24'h003000;
        cpu_we    = 1'b0;
        cpu_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cpu_start = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (sdc_start) hi++;
            stray_ack = (k == 2);
        end
        stray_ack = 1'b0;
        check("busy hold sdc_start", hi, 64'd0);
        check("busy hold no ack", ack_events - a0, 64'd0);
        check("busy hold cpu_busy", cpu_busy, 64'd1);
        sdc_busy = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 50 && !got; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (cpu_ack) begin
                got = 1'b1;
                q   = cpu_q;
            end
        end
        check("busy release ack", got, 64'd1);
        check("busy release cpu_q", q, mem_rd(24'h003000));
        check("busy release one fill", rd_starts - r0, 64'd1);
        check("busy release fill addr", last_rd_addr, 64'h003000);
        repeat (2) @(negedge clk);

        // Stray sdc_ack while idle
        @(negedge clk);
        stray_ack = 1'b1;
        @(negedge clk);
        stray_ack = 1'b0;
        check("stray ack idle", {cpu_busy, cpu_ack, sdc_start}, 64'd0);

        // cpu_start held while busy is neither re-accepted nor queued
        sdram_lat = 6;
        r0 = rd_starts;
        a0 = ack_events;
        @(negedge clk);
        cpu_addr  = 24'h005008;
        cpu_we    = 1'b0;
        cpu_start = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            @(negedge clk);
        end
        cpu_start = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 50 && !got; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (cpu_ack) begin
                got = 1'b1;
                q   = cpu_q;
            end
        end
        check("no queue ack", got, 64'd1);
        check("no queue cpu_q", q, mem_rd(24'h005008));
        extra = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (cpu_busy) extra++;
        end
        check("no queue busy after", extra, 64'd0);
        check("no queue ack count", ack_events - a0, 64'd1);
        check("no queue one fill", rd_starts - r0, 64'd1);

        // Reset during MISS_WAIT abandons the fill
        sdram_lat = 20;
        r0 = rd_starts;
        a0 = ack_events;
        @(negedge clk);
        cpu_addr  = 24'h006018;
        cpu_we    = 1'b0;
        cpu_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cpu_start = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (sdc_start) got = 1'b1;
        end
        check("midreset fill started", got, 64'd1);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midreset sdc_start drop", sdc_start, 64'd0);
        check("midreset idle", cpu_busy, 64'd0);
        reset = 1'b0;
        check("midreset no ack", ack_events - a0, 64'd0);
        sdram_lat = 2;
        do_req("midreset reread", 24'h006018, 1'b0, 32'h0, q, lat, acks);
        check("midreset refetch", rd_starts - r0, 64'd2);
        check("midreset cpu_q", q, mem_rd(24'h006018));
        do_req("midreset hit", 24'h00601B, 1'b0, 32'h0, q, lat, acks);
        check("midreset hit latency", lat, 64'd2);
        check("midreset hit cpu_q", q, mem_rd(24'h00601B));

        // Randomized traffic against the reference model
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 128; i++) m_valid[i] = 1'b0;
        idx_pool[0] = 7'd0;
        idx_pool[1] = 7'd5;
        idx_pool[2] = 7'd64;
        idx_pool[3] = 7'd127;
        tag_pool[0] = 14'h0000;
        tag_pool[1] = 14'h0001;
        tag_pool[2] = 14'h3FFF;
        for (int i = 0; i < 60; i++) begin
            logic [6:0]  idx;
            logic [13:0] tag;
            logic [23:0] a;
            logic        w;
            logic [31:0] d;
            logic [31:0] exp_q;
            bit          exp_hit;
            idx = idx_pool[$urandom_range(0, 3)];
            tag = tag_pool[$urandom_range(0, 2)];
            a   = {tag, idx, 3'($urandom_range(0, 7))};
            w   = ($urandom_range(0, 2) == 0);
            d   = $urandom;
            sdram_lat = $urandom_range(1, 4);
            exp_hit = m_valid[idx] && (m_tag[idx] == tag);
            exp_q   = mem_rd(a);
            r0 = rd_starts;
            w0 = wr_starts;
            do_req($sformatf("rnd%0d", i), a, w, d, q, lat, acks);
            check($sformatf("rnd%0d ack count", i), acks, 64'd1);
            if (w) begin
                check($sformatf("rnd%0d write", i), {wr_starts - w0, rd_starts - r0}, {32'd1, 32'd0});
                check($sformatf("rnd%0d write addr/data", i), {last_wr_addr, last_wr_data}, {a, d});
            end else begin
                check($sformatf("rnd%0d cpu_q", i), q, exp_q);
                check($sformatf("rnd%0d fills", i), rd_starts - r0, exp_hit ? 64'd0 : 64'd1);
                if (exp_hit) check($sformatf("rnd%0d hit latency", i), lat, 64'd2);
                else begin
                    m_valid[idx] = 1'b1;
                    m_tag[idx]   = tag;
                end
            end
        end

        check("sdram handshake stable", proto_err, 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
